// File: rtl/ram_sp_arbiter.sv
// Two-port arbiter and sequencer for a single-port synchronous RAM (round-robin A/B grant).
// Define RAM_ARB_FIXED_PRIO_EN to give port A fixed priority and remove the round-robin pointer.
module ram_sp_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  a_rsp_valid,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

    state_t                state;
    logic                  grant_a;
    logic                  grant_b;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  owner_b;
    logic [DATA_WIDTH-1:0] wdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                  prefer_b;
`endif

    // Grant selection; only meaningful in IDLE and forced low while reset is asserted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && state == IDLE) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant_a = a_req_valid;
            grant_b = b_req_valid && !a_req_valid;
`else
            grant_a = a_req_valid && (!b_req_valid || !prefer_b);
            grant_b = b_req_valid && (!a_req_valid || prefer_b);
`endif
        end
        sel_we    = grant_b ? b_req_we    : a_req_we;
        sel_addr  = grant_b ? b_req_addr  : a_req_addr;
        sel_wdata = grant_b ? b_req_wdata : a_req_wdata;
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign accept      = grant_a || grant_b;

    // ram_we is high only in WRITE, so it doubles as the bus drive enable.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_address <= '0;
            wdata_q     <= '0;
            owner_b     <= 1'b0;
            rsp_rdata   <= '0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            busy        <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            prefer_b    <= 1'b0;
`endif
        end else begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_b     <= grant_b;
                        ram_address <= sel_addr;
                        wdata_q     <= sel_wdata;
                        ram_cs      <= 1'b1;
                        ram_we      <= sel_we;
                        ram_oe      <= !sel_we;
                        busy        <= 1'b1;
                        state       <= sel_we ? WRITE : READ;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        prefer_b    <= grant_a;
`endif
                    end
                end
                WRITE: begin
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata   <= ram_data;
                    a_rsp_valid <= !owner_b;
                    b_rsp_valid <= owner_b;
                    ram_cs      <= 1'b0;
                    ram_oe      <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_sp_arbiter.md
# ram_sp_arbiter

Two-port request arbiter and sequencer for the single-port synchronous RAM (`ram_sp_sr_sw`). It accepts independent read/write requests from requesters A and B and grants them round-robin. It drives the RAM's address, chip-select, write-enable and output-enable pins plus its bidirectional data bus, and returns read data to the winning requester. It sits between the RAM instance and the datapath blocks that share it.

## Interface
- `DATA_WIDTH`, 64: RAM word width; must match the RAM instance.
- `ADDR_WIDTH`, 8: RAM address width; must match the RAM instance.

Ports:
- `clk`  in  1: single clock; rising edge; same clock as the RAM.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a_req_valid`, `b_req_valid`  in  1: requester has a command.
- `a_req_ready`, `b_req_ready`  out  1: command accepted this cycle when high together with valid.
- `a_req_we`, `b_req_we`  in  1: 1 = write, 0 = read.
- `a_req_addr`, `b_req_addr`  in  ADDR_WIDTH: word address.
- `a_req_wdata`, `b_req_wdata`  in  DATA_WIDTH: write data.
- `a_rsp_valid`, `b_rsp_valid`  out  1: one-cycle pulse; `rsp_rdata` holds read data for that port.
- `rsp_rdata`  out  DATA_WIDTH: shared read-data register.
- `busy`  out  1: high in any state other than IDLE.
- `ram_address`  out  ADDR_WIDTH: RAM address pin.
- `ram_cs`, `ram_we`, `ram_oe`  out  1: RAM control pins.
- `ram_data`  inout  DATA_WIDTH: RAM data bus. Driven only in WRITE; high-Z otherwise.

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE:
  - `x_req_ready = grant_x`, combinational. When only one port is valid, that port is granted.
  - When both ports are valid, the port not served last is granted.
  - On accept, the controller registers addr, we and wdata plus an owner bit, updates the round-robin pointer, and moves to WRITE if we=1, else READ.
- WRITE, 1 cycle:
  - `ram_cs=1`, `ram_we=1`, `ram_oe=0`.
  - `ram_data` driven with the registered wdata. The RAM commits at the end of this cycle.
  - Next state is IDLE. No response is returned for writes.
- READ, 1 cycle:
  - `ram_cs=1`, `ram_we=0`, `ram_oe=1`, `ram_data` high-Z.
  - The RAM loads its output register at the end of this cycle. Next state is CAPTURE.
- CAPTURE, 1 cycle:
  - Same pin values as READ and same address. The bus now carries valid data.
  - At the end of the cycle `rsp_rdata <= ram_data` and the owner's `rsp_valid` is set. Next state is IDLE.
- `rsp_valid` is high for exactly the one IDLE cycle after CAPTURE. Responses have no backpressure.
- `req_ready` is 0 in every non-IDLE state. Requesters must hold valid and the request fields until accepted.
- Round-robin pointer:
  - Reset value is "A preferred".
  - After A is served, B is preferred. After B is served, A is preferred.
  - The pointer updates only on accept.
- Outside WRITE, READ and CAPTURE: `ram_cs=0`, `ram_we=0`, `ram_oe=0`. `ram_address` holds its last value.

## Timing
- Reset values, applied asynchronously when `rst_n=0`:
  - state IDLE, `ram_cs`/`ram_we`/`ram_oe`=0, `ram_address`=0, `ram_data`=Z.
  - `rsp_rdata`=0, both `rsp_valid`=0, `busy`=0, pointer=A.
  - Both `req_ready` forced to 0 while `rst_n` is low.
- Write latency: accept in cycle N; RAM written at the end of cycle N+1. Peak rate is 1 write per 2 cycles.
- Read latency: accept in cycle N; `rsp_valid` high in cycle N+3. Peak rate is 1 read per 3 cycles.
- A new request may be accepted in the same IDLE cycle that `rsp_valid` is high.
- Bus turnaround: a WRITE directly after CAPTURE is legal. The RAM releases the bus combinationally when `ram_oe`/`ram_we` change, so no idle gap is inserted.
- Reset mid-operation: the in-flight command is discarded and no response is produced. A WRITE interrupted before its clock edge is not committed.
- Read-after-write to the same address from either port returns the new data; there is no hazard because the operations are sequential.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: port A always wins when both are valid. The pointer logic is compiled out, so B can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Write A addr 0x10 data 0x1122334455667788, then read A addr 0x10 -> `a_rsp_valid` 3 cycles after read accept, `rsp_rdata`=0x1122334455667788, `b_rsp_valid` stays 0.
- A and B both valid with reads of 0x01 and 0x02 from reset -> A granted first, B accepted the cycle A's `rsp_valid` pulses, and each gets its own data.
- Both ports hold writes continuously for 8 accepts -> grants alternate A,B,A,B… Under `RAM_ARB_FIXED_PRIO_EN`, all 8 go to A.
- Write B 0x20 immediately followed by read A 0x20 -> `rsp_rdata` equals B's data. `ram_data` is never driven by the arbiter during READ/CAPTURE.
- Assert `rst_n`=0 during CAPTURE -> all outputs take their reset values immediately and no `rsp_valid` appears after release.
- Reset with both valids high -> `req_ready`=0 until `rst_n` rises, then A is granted first.
